// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the default operand width, the 3-bit state codes (also used by the
// seven_seg glyph table, so both sides agree on one encoding), the FSM state
// enum built from those codes, and the datapath control bundle.
package seq_mult_pkg;

  localparam int unsigned WidthDefault = 4;

  // Status codes exported on state_code and decoded by seven_seg.
  localparam logic [2:0] StateIdle  = 3'd0;
  localparam logic [2:0] StateLoad  = 3'd1;
  localparam logic [2:0] StateAdd   = 3'd2;
  localparam logic [2:0] StateShift = 3'd3;
  localparam logic [2:0] StateDone  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = StateIdle,
    StLoad  = StateLoad,
    StAdd   = StateAdd,
    StShift = StateShift,
    StDone  = StateDone
  } state_e;

  // One-hot datapath operation select, driven by the FSM.
  typedef struct packed {
    logic capture;  // latch operands (accepting edge in IDLE)
    logic load;     // clear accumulator, preset bit counter
    logic add;      // conditional accumulate
    logic shift;    // shift operands, decrement counter
  } dp_ctrl_t;

endpackage

// File: rtl/seq_mult_if.sv
// Request/result bundle for seq_mult.
//   start      : request a multiply (honoured only in IDLE)
//   a, b       : multiplicand / multiplier, sampled on the accepting edge
//   product    : registered 2*WIDTH-bit result, updated on DONE entry
//   busy       : high in LOAD, ADD and SHIFT
//   done       : high for the single DONE cycle
//   state_code : live FSM state code for the seven_seg decoder
// master = requester side, slave = multiplier side.
interface seq_mult_if #(
  parameter int unsigned WIDTH = seq_mult_pkg::WidthDefault
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;
  logic [2:0]         state_code;

  modport master (
    output start, a, b,
    input  product, busy, done, state_code
  );

  modport slave (
    input  start, a, b,
    output product, busy, done, state_code
  );

endinterface

// File: rtl/seq_mult_dp.sv
// Datapath of the shift-add multiplier: operand registers (mcand, mplr),
// accumulator, bit counter, adder and the product output register.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   ctrl_i            : one-hot operation select from the FSM
//   latch_i           : copy acc into product (asserted on the DONE-entry edge)
//   a_i, b_i          : operands, captured when ctrl_i.capture is set
//   product_o         : registered product
//   cnt_last_o        : counter holds 1 (final add/shift pair in progress)
//   mplr_rest_zero_o  : multiplier is zero once shifted right by one
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  dp_ctrl_t           ctrl_i,
  input  logic               latch_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               cnt_last_o,
  output logic               mplr_rest_zero_o
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (1'b1)
      ctrl_i.capture: begin
        mcand_d = PW'(a_i);
        mplr_d  = b_i;
      end
      ctrl_i.load: begin
        acc_d = '0;
        cnt_d = CntW'(WIDTH);
      end
      ctrl_i.add: begin
        // Wraps modulo 2^PW, but the true product always fits.
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
      end
      ctrl_i.shift: begin
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CntW'(1);
      end
      default: ;
    endcase

    // acc is stable during SHIFT, so the final sum is ready on this edge.
    if (latch_i) product_d = acc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product_o        = product_q;
  assign cnt_last_o       = (cnt_q == CntW'(1));
  assign mplr_rest_zero_o = ((mplr_q >> 1) == '0);

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add unsigned multiplier, one add/shift pair per bit.
// Exports its FSM state as a 3-bit code for the seven_seg display.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, overrides everything
//   bus  : seq_mult_if slave (start, a, b, product, busy, done, state_code)
// Build option: SEQ_MULT_EARLY_EXIT_EN -- leave SHIFT for DONE as soon as the
// remaining multiplier bits are zero (same result, data-dependent latency).
// Without it the latency is fixed at 2*WIDTH+2 cycles.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input logic       clk,
  input logic       rst,
  seq_mult_if.slave bus
);

`ifdef SEQ_MULT_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  state_e   state_q, state_d;
  dp_ctrl_t ctrl;
  logic     latch;
  logic     cnt_last;
  logic     mplr_rest_zero;
  logic     shift_exit;

  assign shift_exit = cnt_last | (EarlyExit & mplr_rest_zero);

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    latch   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ctrl.capture = 1'b1;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        ctrl.load = 1'b1;
        state_d   = StAdd;
      end
      StAdd: begin
        ctrl.add = 1'b1;
        state_d  = StShift;
      end
      StShift: begin
        ctrl.shift = 1'b1;
        if (shift_exit) begin
          latch   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StAdd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  seq_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i            (clk),
    .rst_i            (rst),
    .ctrl_i           (ctrl),
    .latch_i          (latch),
    .a_i              (bus.a),
    .b_i              (bus.b),
    .product_o        (bus.product),
    .cnt_last_o       (cnt_last),
    .mplr_rest_zero_o (mplr_rest_zero)
  );

  // Status outputs come from the state register only.
  assign bus.busy       = (state_q == StLoad) || (state_q == StAdd) || (state_q == StShift);
  assign bus.done       = (state_q == StDone);
  assign bus.state_code = state_q;

endmodule
